// File: rtl/flex_down_counter_pkg.sv
// flex_down_counter_pkg: shared types for the down-counter / interval timer.
// Holds the timer state encoding used by the counter and its interface users.
package flex_down_counter_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } timer_state_t;

endpackage

// File: rtl/flex_down_counter_if.sv
// flex_down_counter_if: control and status bundle of the interval timer.
// master drives commands and reads status; slave is the counter itself.
interface flex_down_counter_if #(
   parameter int NUM_CNT_BITS = 4
);

   logic                    start;
   logic                    stop;
   logic                    count_enable;
   logic                    auto_reload;
   logic [NUM_CNT_BITS-1:0] reload_val;
   logic [NUM_CNT_BITS-1:0] count_out;
   logic                    terminal_flag;
   logic                    busy;
   logic                    done;

   modport master (
      output start,
      output stop,
      output count_enable,
      output auto_reload,
      output reload_val,
      input  count_out,
      input  terminal_flag,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  stop,
      input  count_enable,
      input  auto_reload,
      input  reload_val,
      output count_out,
      output terminal_flag,
      output busy,
      output done
   );

endinterface

// File: rtl/flex_down_counter.sv
// flex_down_counter: loadable down-counter with one-shot / auto-reload expiry.
// Counts enabled ticks from reload_val to zero and pulses terminal_flag.
module flex_down_counter
   import flex_down_counter_pkg::*;
#(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                clk,
   input  logic                rst,
   flex_down_counter_if.slave  bus
);

   localparam logic [NUM_CNT_BITS-1:0] ZERO = '0;
   localparam logic [NUM_CNT_BITS-1:0] ONE  = NUM_CNT_BITS'(1);

   timer_state_t            state_q;
   timer_state_t            state_d;
   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;
   logic                    flag_q;
   logic                    flag_d;
   logic                    reload_ok;

   // A zero reload never arms the timer, for start and auto-reload alike.
   assign reload_ok = (bus.reload_val != ZERO);

   // Next state/count: stop beats start, start beats ticking.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      flag_d  = 1'b0;
      if (bus.stop) begin
         state_d = IDLE;
         count_d = ZERO;
      end else if (bus.start) begin
         if (reload_ok) begin
            state_d = RUN;
            count_d = bus.reload_val;
         end else begin
            state_d = IDLE;
            count_d = ZERO;
         end
      end else begin
         unique case (state_q)
            IDLE: begin
               count_d = ZERO;
            end
            RUN: begin
               if (bus.count_enable) begin
                  if (count_q > ONE) begin
                     count_d = count_q - ONE;
                  end else begin
                     flag_d = 1'b1;
                     if (bus.auto_reload && reload_ok) begin
                        count_d = bus.reload_val;
                     end else begin
                        count_d = ZERO;
                        state_d = DONE;
                     end
                  end
               end
            end
            DONE: begin
               count_d = ZERO;
            end
            default: begin
               state_d = IDLE;
               count_d = ZERO;
            end
         endcase
      end
   end

   // State, count and flag registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= ZERO;
         flag_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         flag_q  <= flag_d;
      end
   end

   assign bus.count_out     = count_q;
   assign bus.terminal_flag = flag_q;
   assign bus.busy          = (state_q == RUN);
   assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_flex_down_counter.sv
// tb_flex_down_counter: directed scenarios for the interval timer.
// Status is checked as {count_out, terminal_flag, busy, done}.
module tb_flex_down_counter;

   localparam int N = 4;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   flex_down_counter_if #(.NUM_CNT_BITS(N)) bus ();

   flex_down_counter #(.NUM_CNT_BITS(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [N+2:0] obs;
   assign obs = {bus.count_out, bus.terminal_flag, bus.busy, bus.done};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.reload_val = 4'd5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== {4'd5, 3'b010}) begin
         errors++;
         $display("FAIL reset_pre got=%b exp=%b", obs, {4'd5, 3'b010});
      end
      rst = 1'b1;
      bus.start = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++;
         if (obs !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold%0d got=%b exp=%b", i, obs, 7'b0);
         end
      end
      rst = 1'b0;
      bus.start = 1'b0;
      bus.count_enable = 1'b1;
      step();
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL reset_idle got=%b exp=%b", obs, 7'b0);
      end
   endtask

   task automatic test_one_shot();
      logic [N+2:0] exp [4];
      exp[0] = {4'd3, 3'b010};
      exp[1] = {4'd2, 3'b010};
      exp[2] = {4'd1, 3'b010};
      exp[3] = {4'd0, 3'b101};
      bus.reload_val = 4'd3;
      bus.auto_reload = 1'b0;
      bus.count_enable = 1'b1;
      bus.start = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         bus.start = 1'b0;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL oneshot%0d got=%b exp=%b", i, obs, exp[i]);
         end
      end
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs !== {4'd0, 3'b001}) begin
            errors++;
            $display("FAIL oneshot_hold%0d got=%b exp=%b",
                     i, obs, {4'd0, 3'b001});
         end
      end
   endtask

   task automatic test_auto_reload();
      logic [N+2:0] exp [11];
      exp[0]  = {4'd2, 3'b010};
      exp[1]  = {4'd1, 3'b010};
      exp[2]  = {4'd2, 3'b110};
      exp[3]  = {4'd1, 3'b010};
      exp[4]  = {4'd2, 3'b110};
      exp[5]  = {4'd1, 3'b010};
      exp[6]  = {4'd4, 3'b110};
      exp[7]  = {4'd3, 3'b010};
      exp[8]  = {4'd2, 3'b010};
      exp[9]  = {4'd1, 3'b010};
      exp[10] = {4'd4, 3'b110};
      bus.reload_val = 4'd2;
      bus.auto_reload = 1'b1;
      bus.count_enable = 1'b1;
      bus.start = 1'b1;
      for (int i = 0; i < 11; i++) begin
         step();
         bus.start = 1'b0;
         if (i == 4) bus.reload_val = 4'd4;
         checks++;
         if (obs !== exp[i]) begin
            errors++;
            $display("FAIL auto%0d got=%b exp=%b", i, obs, exp[i]);
         end
      end
   endtask

   task automatic test_gapped();
      logic [3:0] exp_cnt [12];
      exp_cnt = '{4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd2,
                  4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd0};
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL gap_stop got=%b exp=%b", obs, 7'b0);
      end
      bus.auto_reload = 1'b0;
      bus.reload_val = 4'd4;
      bus.count_enable = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         bus.count_enable = (k % 3 == 2);
         step();
         checks++;
         if (obs !== {exp_cnt[k], k == 11, k != 11, k == 11}) begin
            errors++;
            $display("FAIL gap%0d got=%b exp=%b", k, obs,
                     {exp_cnt[k], k == 11, k != 11, k == 11});
         end
      end
      bus.count_enable = 1'b0;
      step();
      checks++;
      if (obs !== {4'd0, 3'b001}) begin
         errors++;
         $display("FAIL gap_after got=%b exp=%b", obs, {4'd0, 3'b001});
      end
   endtask

   task automatic test_boundaries();
      int n;
      bus.reload_val = 4'd0;
      bus.count_enable = 1'b1;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL zero_load got=%b exp=%b", obs, 7'b0);
      end
      step();
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL zero_load2 got=%b exp=%b", obs, 7'b0);
      end
      bus.reload_val = 4'd15;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== {4'd15, 3'b010}) begin
         errors++;
         $display("FAIL max_load got=%b exp=%b", obs, {4'd15, 3'b010});
      end
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         n++;
         if (bus.terminal_flag) break;
      end
      checks++;
      if (n !== 15 || bus.count_out !== 4'd0) begin
         errors++;
         $display("FAIL max_ticks got=%0d/%0d exp=15/0", n, bus.count_out);
      end
      bus.reload_val = 4'd9;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== {4'd9, 3'b010}) begin
         errors++;
         $display("FAIL start_en got=%b exp=%b", obs, {4'd9, 3'b010});
      end
      bus.reload_val = 4'd5;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      step();
      checks++;
      if (obs !== {4'd2, 3'b010}) begin
         errors++;
         $display("FAIL restart_pre got=%b exp=%b", obs, {4'd2, 3'b010});
      end
      bus.reload_val = 4'd6;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      checks++;
      if (obs !== {4'd6, 3'b010}) begin
         errors++;
         $display("FAIL restart got=%b exp=%b", obs, {4'd6, 3'b010});
      end
   endtask

   task automatic test_abort();
      bus.reload_val = 4'd2;
      bus.count_enable = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      bus.count_enable = 1'b1;
      step();
      checks++;
      if (obs !== {4'd1, 3'b010}) begin
         errors++;
         $display("FAIL abort_pre got=%b exp=%b", obs, {4'd1, 3'b010});
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL abort got=%b exp=%b", obs, 7'b0);
      end
      step();
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL abort_after got=%b exp=%b", obs, 7'b0);
      end
      bus.reload_val = 4'd3;
      bus.start = 1'b1;
      step();
      checks++;
      if (obs !== {4'd3, 3'b010}) begin
         errors++;
         $display("FAIL abort_arm got=%b exp=%b", obs, {4'd3, 3'b010});
      end
      bus.stop = 1'b1;
      step();
      bus.stop = 1'b0;
      bus.start = 1'b0;
      checks++;
      if (obs !== 7'b0) begin
         errors++;
         $display("FAIL stop_wins got=%b exp=%b", obs, 7'b0);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.stop = 1'b0;
      bus.count_enable = 1'b0;
      bus.auto_reload = 1'b0;
      bus.reload_val = '0;
      step();
      step();
      rst = 1'b0;
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_gapped();
      test_boundaries();
      test_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
